branch_redirect_unit: RTL and testbench

Consumer side of the branch-decision interface. Takes the resolved `branchIdea`/`fC` decision and the target address from the execute stage, owns the program counter, and redirects fetch. It squashes wrong-path instructions with a two-cycle flush and keeps a small return-address stack (RAS) so that calls (`fC`=1) and returns work.

---
 rtl/branch_pkg.sv | 18 +
 rtl/branch_redirect_unit_return_stack.sv | 65 ++++++
 rtl/branch_redirect_unit.sv | 142 ++++++++++++++
 tb/tb_branch_redirect_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch redirect unit.
// Build option: define BRANCH_RAS_EN to include the return-address stack.
package branch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH1 = 2'd1,
    ST_FLUSH2 = 2'd2
  } brState_e;

  localparam logic [4:0] OP_JUMP   = 5'b00011;
  localparam logic [4:0] OP_BRANCH = 5'b00100;

  // fC encodings as seen on the execute-stage decision.
  localparam logic LINK_NONE = 1'b0;
  localparam logic LINK_CALL = 1'b1;

endpackage

// File: rtl/branch_redirect_unit_return_stack.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
// Only instantiated when BRANCH_RAS_EN is defined.
module return_stack
  import branch_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] pushData_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         overflow_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [W-1:0]    entryQ [DEPTH];
  logic [PtrW-1:0] topPtrQ, topPtrD, pushPtr;
  logic [CntW-1:0] countQ, countD;

  assign full_o     = (countQ == CntFull);
  assign empty_o    = (countQ == '0);
  assign overflow_o = push_i && full_o;
  assign pushPtr    = topPtrQ + PtrW'(1);
  assign top_o      = entryQ[topPtrQ];

  // Count saturates at DEPTH; the pointer keeps wrapping so the oldest entry is lost.
  always_comb begin
    topPtrD = topPtrQ;
    countD  = countQ;
    if (push_i) begin
      topPtrD = pushPtr;
      if (!full_o) begin
        countD = countQ + CntW'(1);
      end
    end else if (pop_i && !empty_o) begin
      topPtrD = topPtrQ - PtrW'(1);
      countD  = countQ - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      topPtrQ <= '0;
      countQ  <= '0;
    end else begin
      topPtrQ <= topPtrD;
      countQ  <= countD;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      entryQ[pushPtr] <= pushData_i;
    end
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Owns the fetch PC, redirects on resolved branches/returns and squashes two wrong-path cycles.
// Build option: BRANCH_RAS_EN adds the return-address stack; otherwise returns use brTarget.
module branch_redirect_unit
  import branch_pkg::*;
#(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            brValid,
  input  logic            branchIdea,
  input  logic            fC,
  input  logic            retValid,
  input  logic [PC_W-1:0] brPc,
  input  logic [PC_W-1:0] brTarget,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic [PC_W-1:0] linkAddr,
  output logic            linkValid,
  output logic            rasOverflow,
  output logic            rasUnderflow
);

  localparam logic [PC_W-1:0] PcOne = PC_W'(1);

  brState_e        stateQ, stateD;
  logic [PC_W-1:0] pcQ, pcD;
  logic [PC_W-1:0] linkAddrQ, linkAddrD;
  logic            linkValidQ, linkValidD;
  logic            takenBranch;
  logic            acceptEvent;

  assign takenBranch = brValid && branchIdea;
  assign acceptEvent = !stall && (stateQ == ST_RUN);

`ifdef BRANCH_RAS_EN
  logic            rasPush, rasPop;
  logic [PC_W-1:0] rasTop;
  logic            rasEmpty, rasFull, rasOverflowNow;
  logic            rasOverflowQ, rasUnderflowQ, rasUnderflowD;

  assign rasPush = acceptEvent && takenBranch && (fC == LINK_CALL);
  assign rasPop  = acceptEvent && !takenBranch && retValid && !rasEmpty;

  return_stack #(
    .W    (PC_W),
    .DEPTH(RAS_DEPTH)
  ) u_returnStack (
    .clk       (clk),
    .reset     (reset),
    .push_i    (rasPush),
    .pop_i     (rasPop),
    .pushData_i(brPc + PcOne),
    .top_o     (rasTop),
    .empty_o   (rasEmpty),
    .full_o    (rasFull),
    .overflow_o(rasOverflowNow)
  );

  assign rasOverflow  = rasOverflowQ;
  assign rasUnderflow = rasUnderflowQ;
`else
  assign rasOverflow  = 1'b0;
  assign rasUnderflow = 1'b0;
`endif

  // Events are only honoured in RUN; flush states just advance past the wrong path.
  always_comb begin
    stateD     = stateQ;
    pcD        = pcQ;
    linkAddrD  = linkAddrQ;
    linkValidD = 1'b0;
`ifdef BRANCH_RAS_EN
    rasUnderflowD = 1'b0;
`endif
    if (!stall) begin
      pcD = pcQ + PcOne;
      unique case (stateQ)
        ST_RUN: begin
          if (takenBranch) begin
            pcD    = brTarget;
            stateD = ST_FLUSH1;
            if (fC == LINK_CALL) begin
              linkAddrD  = brPc + PcOne;
              linkValidD = 1'b1;
            end
          end else if (retValid) begin
            stateD = ST_FLUSH1;
`ifdef BRANCH_RAS_EN
            if (!rasEmpty) begin
              pcD = rasTop;
            end else begin
              pcD           = brTarget;
              rasUnderflowD = 1'b1;
            end
`else
            pcD = brTarget;
`endif
          end
        end
        ST_FLUSH1: stateD = ST_FLUSH2;
        ST_FLUSH2: stateD = ST_RUN;
        default:   stateD = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= ST_RUN;
      pcQ        <= RESET_PC;
      linkAddrQ  <= '0;
      linkValidQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      pcQ        <= pcD;
      linkAddrQ  <= linkAddrD;
      linkValidQ <= linkValidD;
    end
  end

`ifdef BRANCH_RAS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rasOverflowQ  <= 1'b0;
      rasUnderflowQ <= 1'b0;
    end else begin
      rasOverflowQ  <= rasOverflowNow && rasFull;
      rasUnderflowQ <= rasUnderflowD;
    end
  end
`endif

  assign pc        = pcQ;
  assign flush     = (stateQ != ST_RUN);
  assign linkAddr  = linkAddrQ;
  assign linkValid = linkValidQ;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench for branch_redirect_unit; follows BRANCH_RAS_EN for return expectations.
module tb_branch_redirect_unit;

`ifdef BRANCH_RAS_EN
  localparam bit RasOn = 1'b1;
`else
  localparam bit RasOn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic        linkValid;
    logic [31:0] linkAddr;
    logic        rasOverflow;
    logic        rasUnderflow;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset, stall, brValid, branchIdea, fC, retValid;
  logic [31:0] brPc, brTarget;
  logic [31:0] pc, linkAddr;
  logic        flush, linkValid, rasOverflow, rasUnderflow;

  obs_t        expQ[$];
  obs_t        obsQ[$];
  logic [31:0] expLink;
  int          vectorsApplied = 0;
  int          miscompares    = 0;

  branch_redirect_unit #(
    .PC_W     (32),
    .RESET_PC (32'h10),
    .RAS_DEPTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .brValid     (brValid),
    .branchIdea  (branchIdea),
    .fC          (fC),
    .retValid    (retValid),
    .brPc        (brPc),
    .brTarget    (brTarget),
    .pc          (pc),
    .flush       (flush),
    .linkAddr    (linkAddr),
    .linkValid   (linkValid),
    .rasOverflow (rasOverflow),
    .rasUnderflow(rasUnderflow)
  );

  always #5 clk = ~clk;

  function automatic obs_t ex(input logic [31:0] p, input logic fl, input logic lv,
                              input logic ov, input logic un);
    obs_t r;
    r.pc           = p;
    r.flush        = fl;
    r.linkValid    = lv;
    r.linkAddr     = expLink;
    r.rasOverflow  = ov;
    r.rasUnderflow = un;
    return r;
  endfunction

  // Drive one cycle, queue its expected result, then record what the DUT shows after the edge.
  task automatic applyStimulus(input logic rst, input logic stl, input logic bv, input logic bi,
                               input logic fc, input logic rv, input logic [31:0] bpc,
                               input logic [31:0] btgt, input obs_t e);
    obs_t o;
    reset      = rst;
    stall      = stl;
    brValid    = bv;
    branchIdea = bi;
    fC         = fc;
    retValid   = rv;
    brPc       = bpc;
    brTarget   = btgt;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    o.pc           = pc;
    o.flush        = flush;
    o.linkValid    = linkValid;
    o.linkAddr     = linkAddr;
    o.rasOverflow  = rasOverflow;
    o.rasUnderflow = rasUnderflow;
    obsQ.push_back(o);
  endtask

  task automatic idle(input logic [31:0] p, input logic fl);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ex(p, fl, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic test_reset;
    obs_t e, o;
    int idx = 0;
    expLink = 32'h0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h7, 32'h55, ex(32'h10, 1'b0, 1'b0, 1'b0, 1'b0));
    idle(32'h11, 1'b0);
    idle(32'h12, 1'b0);
    idle(32'h13, 1'b0);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectorsApplied++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL reset[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_taken_branch;
    obs_t e, o;
    int idx = 0;
    for (int p = 32'h14; p <= 32'h20; p++) idle(32'(p), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h80, ex(32'h80, 1'b1, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h21, 32'h300, ex(32'h81, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(32'h82, 1'b0);
    idle(32'h83, 1'b0);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectorsApplied++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL taken_branch[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_call_return;
    obs_t e, o;
    int idx = 0;
    logic [31:0] dest;
    expLink = 32'h31;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h100, ex(32'h100, 1'b1, 1'b1, 1'b0, 1'b0));
    idle(32'h101, 1'b1);
    idle(32'h102, 1'b0);
    dest = RasOn ? 32'h31 : 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h102, 32'h0, ex(dest, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(dest + 32'h1, 1'b1);
    idle(dest + 32'h2, 1'b0);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectorsApplied++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL call_return[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_nested_calls;
    obs_t e, o;
    int idx = 0;
    logic [31:0] tgt, dest;
    for (int i = 1; i <= 5; i++) begin
      tgt     = 32'h200 + 32'(i) * 32'h10;
      expLink = 32'(i) + 32'h1;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'(i), tgt,
                    ex(tgt, 1'b1, 1'b1, RasOn && (i == 5), 1'b0));
      idle(tgt + 32'h1, 1'b1);
      idle(tgt + 32'h2, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      tgt  = 32'h400 + 32'(k) * 32'h10;
      dest = (RasOn && k < 4) ? 32'(6 - k) : tgt;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, tgt,
                    ex(dest, 1'b1, 1'b0, 1'b0, RasOn && (k == 4)));
      idle(dest + 32'h1, 1'b1);
      idle(dest + 32'h2, 1'b0);
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectorsApplied++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL nested_calls[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_priority;
    obs_t e, o;
    int idx = 0;
    logic [31:0] dest;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h9, 32'h600, ex(32'h600, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(32'h601, 1'b1);
    idle(32'h602, 1'b0);
    // Not-taken with fC set: plain increment, no link.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 32'h999, ex(32'h603, 1'b0, 1'b0, 1'b0, 1'b0));
    expLink = 32'h41;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h700, ex(32'h700, 1'b1, 1'b1, 1'b0, 1'b0));
    idle(32'h701, 1'b1);
    idle(32'h702, 1'b0);
    // Taken branch alongside a return: return must not pop.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h702, 32'h800, ex(32'h800, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(32'h801, 1'b1);
    idle(32'h802, 1'b0);
    dest = RasOn ? 32'h41 : 32'h900;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h802, 32'h900, ex(dest, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(dest + 32'h1, 1'b1);
    idle(dest + 32'h2, 1'b0);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectorsApplied++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL priority[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_stall;
    obs_t e, o;
    int idx = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1, 32'h500, ex(32'h500, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h77, 32'hABC, ex(32'h500, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    idle(32'h501, 1'b1);
    idle(32'h502, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h88, 32'hDEF, ex(32'h502, 1'b0, 1'b0, 1'b0, 1'b0));
    idle(32'h503, 1'b0);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectorsApplied++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL stall[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_wrap;
    obs_t e, o;
    int idx = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h503, 32'hFFFF_FFFF,
                  ex(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(32'h0, 1'b1);
    idle(32'h1, 1'b0);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectorsApplied++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL wrap[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_reset_midflush;
    obs_t e, o;
    int idx = 0;
    expLink = 32'h61;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h60, 32'hA00, ex(32'hA00, 1'b1, 1'b1, 1'b0, 1'b0));
    idle(32'hA01, 1'b1);
    idle(32'hA02, 1'b0);
    expLink = 32'h71;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h70, 32'hB00, ex(32'hB00, 1'b1, 1'b1, 1'b0, 1'b0));
    idle(32'hB01, 1'b1);
    idle(32'hB02, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hB02, 32'hC00, ex(32'hC00, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(32'hC01, 1'b1);
    expLink = 32'h0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ex(32'h10, 1'b0, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hD00, ex(32'hD00, 1'b1, 1'b0, 1'b0, RasOn));
    idle(32'hD01, 1'b1);
    idle(32'hD02, 1'b0);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      vectorsApplied++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL reset_midflush[%0d]: got %p, want %p", idx, o, e);
      end
      idx++;
    end
  endtask

  initial begin
    reset      = 1'b0;
    stall      = 1'b0;
    brValid    = 1'b0;
    branchIdea = 1'b0;
    fC         = 1'b0;
    retValid   = 1'b0;
    brPc       = 32'h0;
    brTarget   = 32'h0;
    expLink    = 32'h0;
    $display("[TB] starting, return stack %s", RasOn ? "enabled" : "disabled");
    test_reset();
    test_taken_branch();
    test_call_return();
    test_nested_calls();
    test_priority();
    test_stall();
    test_wrap();
    test_reset_midflush();
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
